// File: rtl/align_p2s_feeder_pkg.sv
// ============================================================================
// align_p2s_feeder_pkg : shared constants and pacer state decode for the
//                        serializer feeder.
// Revision: 1.0
// ============================================================================
`default_nettype none

package align_p2s_feeder_pkg;

  localparam int SEG_NUM_MIN    = 1;
  localparam int SEG_NUM_MAX    = 16;
  localparam int DATA_WIDTH_DEF = 256;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int GAP_W          = $clog2(SEG_NUM_MAX);

  typedef enum logic [1:0] {
    PACER_IDLE  = 2'd0,
    PACER_READY = 2'd1,
    PACER_GAP   = 2'd2
  } pacer_state_e;

  // The pacer keeps no explicit state register; this decodes it from gap/level.
  function automatic pacer_state_e pacer_state(input logic [GAP_W-1:0] gap,
                                               input logic level_nz);
    if (gap != '0) return PACER_GAP;
    if (level_nz)  return PACER_READY;
    return PACER_IDLE;
  endfunction

endpackage

`default_nettype wire

// File: rtl/align_p2s_feeder_if.sv
// ============================================================================
// align_p2s_feeder_if : upstream valid/ready word bus plus the downstream
//                       issue pulse towards the serializer.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface align_p2s_feeder_if
  import align_p2s_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;

  modport master (output s_data, output s_valid, input s_ready,
                  input m_data, input m_valid);
  modport slave  (input s_data, input s_valid, output s_ready,
                  output m_data, output m_valid);
endinterface

`default_nettype wire

// File: rtl/align_sync_fifo.sv
// ============================================================================
// align_sync_fifo : small synchronous FIFO with separately tracked level and
//                   synchronous flush. Storage is not reset.
// Revision: 1.0
// ============================================================================
`default_nettype none

module align_sync_fifo #(
  parameter int DATA_WIDTH = 256,
  parameter int DEPTH      = 4
)(
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  logic [DATA_WIDTH-1:0]        wdata_i,
  input  logic                         pop_i,
  output logic [DATA_WIDTH-1:0]        rdata_o,
  output logic [$clog2(DEPTH+1)-1:0]   level_o,
  output logic                         full_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH+1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]      level_q, level_d;
  logic                  w_push, w_pop;

  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign w_push  = push_i && !full_o && !flush_i;
  assign w_pop   = pop_i && (level_q != '0) && !flush_i;
  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = level_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      // DEPTH is a power of two, so natural pointer overflow is the wrap.
      if (w_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (w_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

`default_nettype wire

// File: rtl/align_p2s_feeder.sv
// ============================================================================
// align_p2s_feeder : elastic buffer + issue pacer ahead of the wide-to-narrow
//                    serializer; issues one m_valid pulse per SEG_NUM cycles.
// Optional counters: ALIGN_P2S_FEEDER_STATS_EN (issue_cnt_o / stall_cnt_o).
// Revision: 1.0
// ============================================================================
`default_nettype none

module align_p2s_feeder
  import align_p2s_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int SEG_NUM    = 4,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
)(
  input  logic                              clk,
  input  logic                              rstn,
  input  logic                              flush_i,
  align_p2s_feeder_if.slave                 bus,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   level_o,
  output logic                              busy_o
`ifdef ALIGN_P2S_FEEDER_STATS_EN
  ,
  output logic [31:0]                       issue_cnt_o,
  output logic [31:0]                       stall_cnt_o
`endif
);
  localparam int                 LVL_W      = $clog2(FIFO_DEPTH+1);
  localparam logic [GAP_W-1:0]   GAP_RELOAD = GAP_W'(SEG_NUM - 1);

  logic [DATA_WIDTH-1:0] w_head;
  logic [LVL_W-1:0]      w_level;
  logic                  w_full;
  logic                  w_pop;
  pacer_state_e          w_state;

  logic                  m_valid_q, m_valid_d;
  logic [DATA_WIDTH-1:0] m_data_q,  m_data_d;
  logic [GAP_W-1:0]      gap_q,     gap_d;

  align_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .flush_i (flush_i),
    .push_i  (bus.s_valid),
    .wdata_i (bus.s_data),
    .pop_i   (w_pop),
    .rdata_o (w_head),
    .level_o (w_level),
    .full_o  (w_full)
  );

  assign w_state = pacer_state(gap_q, w_level != '0);
  assign w_pop   = (w_state == PACER_READY) && !flush_i;

  always_comb begin
    m_valid_d = 1'b0;
    m_data_d  = m_data_q;
    gap_d     = gap_q;
    if (flush_i) begin
      gap_d = '0;
    end else if (w_pop) begin
      m_valid_d = 1'b1;
      m_data_d  = w_head;
      gap_d     = GAP_RELOAD;
    end else if (gap_q != '0) begin
      gap_d = gap_q - GAP_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      gap_q     <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      gap_q     <= gap_d;
    end
  end

  // Ready is purely level based; a same-cycle pop does not free a slot early.
  assign bus.s_ready = !w_full;
  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = m_data_q;
  assign level_o     = w_level;
  assign busy_o      = (w_level != '0) || (gap_q != '0);

`ifdef ALIGN_P2S_FEEDER_STATS_EN
  logic [31:0] issue_cnt_q;
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      issue_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else if (flush_i) begin
      issue_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (m_valid_q && (issue_cnt_q != '1))
        issue_cnt_q <= issue_cnt_q + 32'd1;
      if (bus.s_valid && !bus.s_ready && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign issue_cnt_o = issue_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_align_p2s_feeder.sv
// ============================================================================
// tb_align_p2s_feeder : directed bench for two feeder instances (SEG_NUM=4 and
//                       SEG_NUM=1) against a queue-based timing model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_align_p2s_feeder;
  localparam int DW    = 256;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH+1);
  localparam int SEG0  = 4;
  localparam int SEG1  = 1;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic          sv      [2];
  logic [DW-1:0] sd      [2];
  logic          flush_v [2];

  logic          act_mv [2], act_rdy [2], act_busy [2];
  logic [DW-1:0] act_md [2];
  logic [LW-1:0] act_lvl[2];

  align_p2s_feeder_if #(.DATA_WIDTH(DW)) bus0 ();
  align_p2s_feeder_if #(.DATA_WIDTH(DW)) bus1 ();

`ifdef ALIGN_P2S_FEEDER_STATS_EN
  logic [31:0] issue0, stall0, issue1, stall1;
`endif

  align_p2s_feeder #(.DATA_WIDTH(DW), .SEG_NUM(SEG0), .FIFO_DEPTH(DEPTH)) dut0 (
    .clk (clk), .rstn (rstn), .flush_i (flush_v[0]), .bus (bus0),
    .level_o (act_lvl[0]), .busy_o (act_busy[0])
`ifdef ALIGN_P2S_FEEDER_STATS_EN
    , .issue_cnt_o (issue0), .stall_cnt_o (stall0)
`endif
  );

  align_p2s_feeder #(.DATA_WIDTH(DW), .SEG_NUM(SEG1), .FIFO_DEPTH(DEPTH)) dut1 (
    .clk (clk), .rstn (rstn), .flush_i (flush_v[1]), .bus (bus1),
    .level_o (act_lvl[1]), .busy_o (act_busy[1])
`ifdef ALIGN_P2S_FEEDER_STATS_EN
    , .issue_cnt_o (issue1), .stall_cnt_o (stall1)
`endif
  );

  assign bus0.s_valid = sv[0];
  assign bus0.s_data  = sd[0];
  assign bus1.s_valid = sv[1];
  assign bus1.s_data  = sd[1];
  assign act_mv[0]  = bus0.m_valid;
  assign act_md[0]  = bus0.m_data;
  assign act_rdy[0] = bus0.s_ready;
  assign act_mv[1]  = bus1.m_valid;
  assign act_md[1]  = bus1.m_data;
  assign act_rdy[1] = bus1.s_ready;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic int seg_of(input int k);
    return (k == 0) ? SEG0 : SEG1;
  endfunction

  // Model: a word queue plus the edge number of the last issue; a word is
  // issued when queued before the edge and at least SEG_NUM edges have passed.
  logic [DW-1:0] mq [2][$];
  int            last_iss [2];
  int            ecnt = 0;
  int            pre_sz;
  logic          exp_mv  [2];
  logic [DW-1:0] exp_md  [2];
  int            exp_lvl [2];
  logic          exp_busy[2];
  logic          exp_rdy [2];

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < 2; k++) begin
        mq[k].delete();
        last_iss[k] = -1000;
        exp_mv[k]   = 1'b0;
        exp_md[k]   = '0;
        exp_lvl[k]  = 0;
        exp_busy[k] = 1'b0;
        exp_rdy[k]  = 1'b1;
      end
    end else begin
      ecnt++;
      for (int k = 0; k < 2; k++) begin
        pre_sz    = mq[k].size();
        exp_mv[k] = 1'b0;
        if (flush_v[k]) begin
          mq[k].delete();
          last_iss[k] = -1000;
        end else begin
          if (pre_sz > 0 && (ecnt - last_iss[k]) >= seg_of(k)) begin
            exp_md[k]   = mq[k].pop_front();
            exp_mv[k]   = 1'b1;
            last_iss[k] = ecnt;
          end
          if (sv[k] && pre_sz < DEPTH) mq[k].push_back(sd[k]);
        end
        exp_lvl[k]  = mq[k].size();
        exp_rdy[k]  = (mq[k].size() < DEPTH);
        exp_busy[k] = (mq[k].size() > 0) || ((ecnt - last_iss[k]) < seg_of(k) - 1);
      end
    end
  end

  // Downstream serializer stand-in on instance 0: 4 x 64-bit segments, LSB first.
  logic [DW-1:0] sbuf;
  int            sidx;
  logic          sact;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sact <= 1'b0;
      sidx <= 0;
      sbuf <= '0;
    end else if (act_mv[0]) begin
      sbuf <= act_md[0];
      sidx <= 0;
      sact <= 1'b1;
    end else if (sact) begin
      if (sidx == 3) sact <= 1'b0;
      else           sidx <= sidx + 1;
    end
  end

  int            pe [2][$];
  logic [DW-1:0] pd [2][$];
  logic [63:0]   seg_q[$];
  int            seg_t[$];
  logic          ser_on = 1'b0;

  always @(posedge clk) begin
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("m_valid%0d", k), DW'(act_mv[k]),   DW'(exp_mv[k]));
      chk($sformatf("m_data%0d", k),  act_md[k],        exp_md[k]);
      chk($sformatf("level%0d", k),   DW'(act_lvl[k]),  DW'(exp_lvl[k]));
      chk($sformatf("s_ready%0d", k), DW'(act_rdy[k]),  DW'(exp_rdy[k]));
      chk($sformatf("busy%0d", k),    DW'(act_busy[k]), DW'(exp_busy[k]));
      if (act_mv[k]) begin
        pe[k].push_back(ecnt);
        pd[k].push_back(act_md[k]);
      end
    end
    if (ser_on && sact) begin
      seg_q.push_back(sbuf[sidx*64 +: 64]);
      seg_t.push_back(ecnt);
    end
  end

  logic [DW-1:0] sent_q[$];
  logic          saw_full;
  int            max_lvl;
  int            wid = 0;

  function automatic logic [DW-1:0] make_word(input int mode);
    logic [DW-1:0] w;
    wid++;
    if (mode == 2) begin
      w = {(DW/8){8'hA5}};
    end else if (mode == 1) begin
      for (int j = 0; j < DW/32; j++) w[j*32 +: 32] = $urandom;
    end else begin
      w = {(DW/32){32'h5A00_0000 | 32'(wid)}};
    end
    return w;
  endfunction

  // Entered on a negedge; holds s_valid until n words have been accepted.
  task automatic push_stream(input int k, input int n, input int mode);
    logic [DW-1:0] w;
    logic          acc;
    int            i;
    int            guard;
    i = 0;
    guard = 0;
    w = make_word(mode);
    sent_q.push_back(w);
    sv[k] = 1'b1;
    sd[k] = w;
    while (i < n) begin
      acc = act_rdy[k];
      if (!acc) saw_full = 1'b1;
      if (int'(act_lvl[k]) > max_lvl) max_lvl = int'(act_lvl[k]);
      @(negedge clk);
      guard++;
      if (acc) begin
        i++;
        if (i < n) begin
          w = make_word(mode);
          sent_q.push_back(w);
          sd[k] = w;
        end else begin
          sv[k] = 1'b0;
        end
      end
      if (guard > 500) begin
        n_total++;
        $display("FAIL push_timeout%0d: accepted %0d of %0d", k, i, n);
        sv[k] = 1'b0;
        i = n;
      end
    end
  endtask

  task automatic wait_edge(input int n);
    int g;
    g = 0;
    while (ecnt < n && g < 1000) begin
      @(negedge clk);
      g++;
    end
    if (ecnt < n) begin
      n_total++;
      $display("FAIL wait_timeout: edge %0d target %0d", ecnt, n);
    end
  endtask

  task automatic clear_logs();
    pe[0].delete(); pe[1].delete();
    pd[0].delete(); pd[1].delete();
    sent_q.delete();
  endtask

  int            e0;
  logic [DW-1:0] wtmp;

  initial begin
    rstn = 1'b0;
    for (int k = 0; k < 2; k++) begin
      sv[k] = 1'b0;
      sd[k] = '0;
      flush_v[k] = 1'b0;
    end
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("reset_s_ready", DW'(act_rdy[0]),  DW'(1'b1));
    chk("reset_level",   DW'(act_lvl[0]),  '0);
    chk("reset_busy",    DW'(act_busy[0]), '0);
    chk("reset_m_data",  act_md[0],        '0);

    // Single word: pulse one edge after the accept edge, busy for 3 more cycles.
    clear_logs();
    e0 = ecnt + 1;
    push_stream(0, 1, 2);
    wait_edge(e0 + 3);
    chk("single_busy_in_gap", DW'(act_busy[0]), DW'(1'b1));
    wait_edge(e0 + 4);
    chk("single_busy_clear", DW'(act_busy[0]), '0);
    wait_edge(e0 + 8);
    chk("single_pulses", DW'(pe[0].size()), DW'(1));
    chk("single_latency", DW'(pe[0][0]), DW'(e0 + 1));
    chk("single_data", pd[0][0], {(DW/8){8'hA5}});
    chk("single_level", DW'(act_lvl[0]), '0);

    // Burst of 6 with s_valid held: spacing 4, in order, back-pressure seen.
    clear_logs();
    saw_full = 1'b0;
    push_stream(0, 6, 0);
    wait_edge(ecnt + 30);
    chk("burst_pulses", DW'(pe[0].size()), DW'(6));
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("burst_data%0d", i), pd[0][i], sent_q[i]);
      if (i > 0) chk($sformatf("burst_gap%0d", i), DW'(pe[0][i] - pe[0][i-1]), DW'(4));
    end
    chk("burst_saw_full", DW'(saw_full), DW'(1'b1));

    // SEG_NUM=1 stream of 8: back-to-back pulses, level stays at most 1.
    clear_logs();
    max_lvl = 0;
    push_stream(1, 8, 0);
    wait_edge(ecnt + 10);
    chk("seg1_pulses", DW'(pe[1].size()), DW'(8));
    for (int i = 1; i < 8; i++)
      chk($sformatf("seg1_gap%0d", i), DW'(pe[1][i] - pe[1][i-1]), DW'(1));
    chk("seg1_data7", pd[1][7], sent_q[7]);
    chk("seg1_max_level_le1", DW'(max_lvl <= 1), DW'(1'b1));

    // Flush with 3 queued during a gap, then a fresh word sees plain latency.
    clear_logs();
    push_stream(0, 4, 0);
    chk("preflush_level", DW'(act_lvl[0]), DW'(3));
    chk("preflush_busy",  DW'(act_busy[0]), DW'(1'b1));
    flush_v[0] = 1'b1;
    @(negedge clk);
    flush_v[0] = 1'b0;
    chk("flush_level",   DW'(act_lvl[0]),  '0);
    chk("flush_m_valid", DW'(act_mv[0]),   '0);
    chk("flush_busy",    DW'(act_busy[0]), '0);
    clear_logs();
    e0 = ecnt + 1;
    push_stream(0, 1, 0);
    wait_edge(e0 + 6);
    chk("postflush_pulses",  DW'(pe[0].size()), DW'(1));
    chk("postflush_latency", DW'(pe[0][0]), DW'(e0 + 1));
    chk("postflush_data",    pd[0][0], sent_q[0]);

    // Reset asserted in the cycle a pop is due: the pop never appears.
    clear_logs();
    push_stream(0, 1, 0);
    rstn = 1'b0;
    @(negedge clk);
    chk("rst_pop_m_valid", DW'(act_mv[0]),  '0);
    chk("rst_pop_level",   DW'(act_lvl[0]), '0);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_release_level", DW'(act_lvl[0]), '0);
    chk("rst_no_pulse",      DW'(pe[0].size()), '0);
`ifdef ALIGN_P2S_FEEDER_STATS_EN
    chk("rst_issue_cnt", DW'(issue0), '0);
    chk("rst_stall_cnt", DW'(stall0), '0);
`endif

    // End to end through the serializer stand-in: 16 random words, 64 segments.
    clear_logs();
    seg_q.delete();
    seg_t.delete();
    ser_on = 1'b1;
    push_stream(0, 16, 1);
    wait_edge(ecnt + 30);
    ser_on = 1'b0;
    chk("ser_segments", DW'(seg_q.size()), DW'(64));
    for (int i = 0; i < 64; i++) begin
      wtmp = sent_q[i/4];
      chk($sformatf("ser_seg%0d", i), DW'(seg_q[i]), DW'(wtmp[(i%4)*64 +: 64]));
    end
    chk("ser_contiguous", DW'(seg_t[63] - seg_t[0]), DW'(63));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
